// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: converts single-word read/write commands into AXI4-Lite
// transactions (one in flight) and returns data/response on a valid/ready port.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    input  logic [2:0]                        cmd_prot,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [7:0]                        error_count,
    output logic                              timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int          STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [31:0] L_TMO  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;

    logic                              r_cmd_ready;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [STRB_W-1:0]                 r_wstrb;
    logic [2:0]                        r_prot;
    logic                              r_awvalid;
    logic                              r_wvalid;
    logic                              r_bready;
    logic                              r_arvalid;
    logic                              r_rready;
    logic                              r_rsp_valid;
    logic                              r_rsp_write;
    logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [1:0]                        r_rsp_resp;
    logic [7:0]                        r_err_cnt;
    logic [31:0]                       r_stall_cnt;
    logic                              r_timeout;

    logic w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs;
    logic w_aw_left, w_w_left, w_waiting, w_any_hs, w_resp_err;

    assign w_cmd_hs  = cmd_valid & r_cmd_ready;
    assign w_aw_hs   = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs    = r_wvalid & M_AXI_WREADY;
    assign w_b_hs    = r_bready & M_AXI_BVALID;
    assign w_ar_hs   = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs    = r_rready & M_AXI_RVALID;
    assign w_rsp_hs  = r_rsp_valid & rsp_ready;
    // A write channel is still outstanding while its VALID is up and not accepted this cycle.
    assign w_aw_left = r_awvalid & ~M_AXI_AWREADY;
    assign w_w_left  = r_wvalid & ~M_AXI_WREADY;
    assign w_waiting = (r_state != S_IDLE) && (r_state != S_RSP);
    assign w_any_hs  = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;
    assign w_resp_err = (w_b_hs && (M_AXI_BRESP != 2'b00)) ||
                        (w_r_hs && (M_AXI_RRESP != 2'b00));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         if (w_cmd_hs) w_state_nxt = cmd_write ? S_WR_ADDR_DATA : S_RD_ADDR;
            S_WR_ADDR_DATA: if (!w_aw_left && !w_w_left) w_state_nxt = S_WR_RESP;
            S_WR_RESP:      if (w_b_hs) w_state_nxt = S_RSP;
            S_RD_ADDR:      if (w_ar_hs) w_state_nxt = S_RD_DATA;
            S_RD_DATA:      if (w_r_hs) w_state_nxt = S_RSP;
            S_RSP:          if (w_rsp_hs) w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cmd_ready <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_prot      <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_prot      <= cmd_prot;
                        r_rsp_write <= cmd_write;
                        r_awvalid   <= cmd_write;
                        r_wvalid    <= cmd_write;
                        r_arvalid   <= ~cmd_write;
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (!w_aw_left && !w_w_left) r_bready <= 1'b1;
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= M_AXI_BRESP;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                    end
                end
                S_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_err_cnt <= '0;
        end else if (w_resp_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Stall counter saturates at the limit; timeout is sticky and never aborts the transfer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_waiting || w_any_hs) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != L_TMO) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((L_TMO != 32'd0) && w_waiting && !w_any_hs && (r_stall_cnt == L_TMO - 32'd1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign error_count   = r_err_cnt;
    assign timeout       = r_timeout;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = r_prot;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = r_prot;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: delay-programmable AXI4-Lite slave plus a
// byte-level memory/response reference model; randomized and directed scenarios.
module tb_axi_lite_cmd_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        cmd_ready, rsp_valid, rsp_write, timeout;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  error_count;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
    logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
    logic [31:0] M_AXI_RDATA = '0;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .error_count(error_count), .timeout(timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc++;

    int errors = 0;
    int checks = 0;

    // Slave configuration and what it observed on the channels.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  cfg_bresp = '0, cfg_rresp = '0;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [2:0]  s_awprot, s_arprot;
    logic [31:0] s_mem [int unsigned];

    initial begin
        bit n_rst, n_aw, n_w, n_b, n_ar, n_r, have_aw, have_w, b_pend, r_pend;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [31:0] cur;
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge ACLK);
            n_rst = ARESET;
            n_aw = M_AXI_AWVALID && M_AXI_AWREADY;
            n_w  = M_AXI_WVALID && M_AXI_WREADY;
            n_b  = M_AXI_BVALID && M_AXI_BREADY;
            n_ar = M_AXI_ARVALID && M_AXI_ARREADY;
            n_r  = M_AXI_RVALID && M_AXI_RREADY;
            if (n_aw) begin s_awaddr = M_AXI_AWADDR; s_awprot = M_AXI_AWPROT; end
            if (n_w)  begin s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; end
            if (n_ar) begin s_araddr = M_AXI_ARADDR; s_arprot = M_AXI_ARPROT; end
            if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_cnt++;
            if (M_AXI_WVALID && !M_AXI_WREADY) w_cnt++;
            if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_cnt++;
            if (b_pend && !M_AXI_BVALID) b_cnt++;
            if (r_pend && !M_AXI_RVALID) r_cnt++;
            @(posedge ACLK); #1;
            if (n_rst) begin
                have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
            end else begin
                if (n_aw) begin have_aw = 1; aw_cnt = 0; end
                if (n_w)  begin have_w = 1; w_cnt = 0; end
                if (have_aw && have_w) begin
                    cur = s_mem.exists(s_awaddr >> 2) ? s_mem[s_awaddr >> 2] : 32'h0;
                    for (int i = 0; i < 4; i++) if (s_wstrb[i]) cur[8*i +: 8] = s_wdata[8*i +: 8];
                    s_mem[s_awaddr >> 2] = cur;
                    have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
                end
                if (n_b) begin M_AXI_BVALID = 1'b0; b_pend = 0; end
                if (b_pend && !M_AXI_BVALID && b_cnt >= b_delay) begin
                    M_AXI_BVALID = 1'b1; M_AXI_BRESP = cfg_bresp;
                end
                if (n_ar) begin
                    r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    M_AXI_RDATA = s_mem.exists(s_araddr >> 2) ? s_mem[s_araddr >> 2] : 32'h0;
                end
                if (n_r) begin M_AXI_RVALID = 1'b0; r_pend = 0; end
                if (r_pend && !M_AXI_RVALID && r_cnt >= r_delay) begin
                    M_AXI_RVALID = 1'b1; M_AXI_RRESP = cfg_rresp;
                end
            end
            M_AXI_AWREADY = (aw_delay == 0) || (aw_cnt >= aw_delay);
            M_AXI_WREADY  = (w_delay == 0) || (w_cnt >= w_delay);
            M_AXI_ARREADY = (ar_delay == 0) || (ar_cnt >= ar_delay);
        end
    end

    // Reference model: byte-addressed register file and saturating error tally.
    logic [31:0] ref_mem [int unsigned];
    int exp_err = 0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = ref_rd(a);
        for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        ref_mem[a >> 2] = cur;
    endtask

    task automatic ref_resp(input logic [1:0] r);
        if (r != 2'b00 && exp_err < 255) exp_err++;
    endtask

    // Per-transaction observations (relative cycle 0 = accept cycle).
    logic [31:0] g_awv_mask, g_wv_mask, g_arv_mask, g_rdata;
    logic [1:0]  g_resp;
    logic        g_rwrite;
    int          g_bready_first, g_tmo_first;
    bit          g_unstable;

    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, output int lat);
        int acc, rel, n;
        bit aw_seen, w_seen, ar_seen;
        logic [34:0] aw_first, ar_first;
        logic [35:0] w_first;
        g_awv_mask = '0; g_wv_mask = '0; g_arv_mask = '0;
        g_bready_first = -1; g_tmo_first = -1; g_unstable = 0; lat = -1;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        s_awaddr = 'x; s_awprot = 'x; s_wdata = 'x; s_wstrb = 'x; s_araddr = 'x; s_arprot = 'x;
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_prot = p;
        rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!cmd_ready && n < 100);
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_wait: cmd_ready=%0b required 1 within 100 cycles", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_prot = 3'($urandom);
        cmd_write = ~wr;
        n = 0;
        forever begin
            @(negedge ACLK);
            rel = cyc - acc;
            if (rel < 32) begin
                g_awv_mask[rel] = M_AXI_AWVALID;
                g_wv_mask[rel]  = M_AXI_WVALID;
                g_arv_mask[rel] = M_AXI_ARVALID;
            end
            if (M_AXI_AWVALID) begin
                if (aw_seen && aw_first !== {M_AXI_AWADDR, M_AXI_AWPROT}) g_unstable = 1;
                aw_seen = 1; aw_first = {M_AXI_AWADDR, M_AXI_AWPROT};
            end
            if (M_AXI_WVALID) begin
                if (w_seen && w_first !== {M_AXI_WDATA, M_AXI_WSTRB}) g_unstable = 1;
                w_seen = 1; w_first = {M_AXI_WDATA, M_AXI_WSTRB};
            end
            if (M_AXI_ARVALID) begin
                if (ar_seen && ar_first !== {M_AXI_ARADDR, M_AXI_ARPROT}) g_unstable = 1;
                ar_seen = 1; ar_first = {M_AXI_ARADDR, M_AXI_ARPROT};
            end
            if (M_AXI_BREADY && g_bready_first < 0) g_bready_first = rel;
            if (timeout && g_tmo_first < 0) g_tmo_first = rel;
            if (rsp_valid) break;
            n++;
            if (n > 5000) break;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_wait: rsp_valid=%0b required 1 within 5000 cycles", rsp_valid);
        end else begin
            lat = cyc - acc;
            g_rdata = rsp_rdata; g_resp = rsp_resp; g_rwrite = rsp_write;
        end
        @(posedge ACLK); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready); end
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_handshakes: got %b required 000000",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid});
        end
        checks++;
        if ({error_count, timeout, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
            errors++; $display("FAIL reset_outputs: err=%0d tmo=%0b rdata=%h resp=%0d wr=%0b required all 0",
                error_count, timeout, rsp_rdata, rsp_resp, rsp_write);
        end
        exp_err = 0;
    endtask

    task automatic test_min_write();
        int lat;
        set_delays(0, 0, 0, 0, 0); cfg_bresp = 2'b00;
        do_txn(1'b1, 32'h0, 32'h0101FFFF, 4'hF, 3'b000, lat);
        ref_wr(32'h0, 32'h0101FFFF, 4'hF); ref_resp(2'b00);
        checks++; if (lat !== 3) begin errors++; $display("FAIL minw_latency: got %0d required 3", lat); end
        checks++; if (g_awv_mask !== 32'h2) begin errors++; $display("FAIL minw_awvalid: got %h required 00000002", g_awv_mask); end
        checks++; if (g_wv_mask !== 32'h2) begin errors++; $display("FAIL minw_wvalid: got %h required 00000002", g_wv_mask); end
        checks++; if (g_bready_first !== 2) begin errors++; $display("FAIL minw_bready: got %0d required 2", g_bready_first); end
        checks++; if ({g_resp, g_rwrite, g_rdata} !== {2'b00, 1'b1, 32'h0}) begin
            errors++; $display("FAIL minw_rsp: resp=%0d wr=%0b rdata=%h required 0/1/0", g_resp, g_rwrite, g_rdata); end
        checks++; if ({s_awaddr, s_awprot, s_wdata, s_wstrb} !== {32'h0, 3'b000, 32'h0101FFFF, 4'hF}) begin
            errors++; $display("FAIL minw_payload: addr=%h data=%h strb=%h required 0/0101ffff/f", s_awaddr, s_wdata, s_wstrb); end
    endtask

    task automatic test_aw_delay();
        int lat;
        set_delays(3, 0, 0, 0, 0); cfg_bresp = 2'b00;
        do_txn(1'b1, 32'h4, 32'hABCD0001, 4'hF, 3'b010, lat);
        ref_wr(32'h4, 32'hABCD0001, 4'hF); ref_resp(2'b00);
        checks++; if (g_wv_mask !== 32'h2) begin errors++; $display("FAIL awdly_wvalid: got %h required 00000002", g_wv_mask); end
        checks++; if (g_awv_mask !== 32'h1E) begin errors++; $display("FAIL awdly_awvalid: got %h required 0000001e", g_awv_mask); end
        checks++; if (g_unstable !== 1'b0) begin errors++; $display("FAIL awdly_stable: got %0b required 0", g_unstable); end
        checks++; if (g_bready_first !== 5) begin errors++; $display("FAIL awdly_bready: got %0d required 5", g_bready_first); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL awdly_latency: got %0d required 6", lat); end
        checks++; if ({s_awaddr, s_awprot} !== {32'h4, 3'b010}) begin
            errors++; $display("FAIL awdly_addr: got %h/%0d required 4/2", s_awaddr, s_awprot); end
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_read_delay();
        int lat;
        set_delays(0, 0, 0, 0, 2); cfg_rresp = 2'b00;
        do_txn(1'b0, 32'h4, 32'h0, 4'h0, 3'b000, lat);
        ref_resp(2'b00);
        checks++; if (g_rdata !== 32'hABCD0001) begin errors++; $display("FAIL rd_data: got %h required abcd0001", g_rdata); end
        checks++; if ({g_resp, g_rwrite} !== 3'b000) begin errors++; $display("FAIL rd_rsp: resp=%0d wr=%0b required 0/0", g_resp, g_rwrite); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency: got %0d required 5", lat); end
        checks++; if (g_arv_mask !== 32'h2) begin errors++; $display("FAIL rd_arvalid: got %h required 00000002", g_arv_mask); end
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_errors();
        int lat;
        logic [31:0] a, d, exp_d;
        set_delays(0, 0, 0, 0, 0); cfg_bresp = 2'b10;
        for (int i = 0; i < 3; i++) begin
            a = 32'($urandom_range(0, 7)) << 2; d = $urandom;
            do_txn(1'b1, a, d, 4'hF, 3'b000, lat);
            ref_wr(a, d, 4'hF); ref_resp(2'b10);
            checks++; if (g_resp !== 2'b10) begin errors++; $display("FAIL err_bresp: got %0d required 2", g_resp); end
        end
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL err_count3: got %0d required %0d", error_count, exp_err); end
        cfg_rresp = 2'b11;
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, 7)) << 2;
            exp_d = ref_rd(a);
            do_txn(1'b0, a, 32'h0, 4'h0, 3'b000, lat);
            ref_resp(2'b11);
            checks++; if ({g_resp, g_rdata} !== {2'b11, exp_d}) begin
                errors++; $display("FAIL err_rresp: resp=%0d data=%h required 3/%h", g_resp, g_rdata, exp_d); end
        end
        checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL err_saturate: got %0d required %0d", error_count, exp_err); end
        cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    task automatic test_random(input int count);
        int lat, exp_lat;
        bit wr;
        logic [31:0] a, d, exp_d;
        logic [3:0] s;
        logic [2:0] p;
        logic [1:0] exp_r;
        for (int i = 0; i < count; i++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
                       $urandom_range(0, 3), $urandom_range(0, 4));
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7)) << 2; d = $urandom; s = 4'($urandom); p = 3'($urandom);
            exp_d   = wr ? 32'h0 : ref_rd(a);
            exp_r   = wr ? cfg_bresp : cfg_rresp;
            exp_lat = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                         : 3 + ar_delay + r_delay;
            do_txn(wr, a, d, s, p, lat);
            if (wr) ref_wr(a, d, s);
            ref_resp(exp_r);
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency: got %0d required %0d", lat, exp_lat); end
            checks++; if ({g_rwrite, g_resp, g_rdata} !== {wr, exp_r, exp_d}) begin
                errors++; $display("FAIL rnd_rsp: wr=%0b resp=%0d data=%h required %0b/%0d/%h",
                    g_rwrite, g_resp, g_rdata, wr, exp_r, exp_d); end
            checks++;
            if (wr && {s_awaddr, s_awprot, s_wdata, s_wstrb} !== {a, p, d, s}) begin
                errors++; $display("FAIL rnd_wpayload: %h/%0d/%h/%h required %h/%0d/%h/%h",
                    s_awaddr, s_awprot, s_wdata, s_wstrb, a, p, d, s); end
            else if (!wr && {s_araddr, s_arprot} !== {a, p}) begin
                errors++; $display("FAIL rnd_rpayload: %h/%0d required %h/%0d", s_araddr, s_arprot, a, p); end
            checks++; if (g_unstable !== 1'b0) begin errors++; $display("FAIL rnd_stable: got %0b required 0", g_unstable); end
            checks++; if (error_count !== 8'(exp_err)) begin errors++; $display("FAIL rnd_errcnt: got %0d required %0d", error_count, exp_err); end
        end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rnd_no_timeout: got %0b required 0", timeout); end
        set_delays(0, 0, 0, 0, 0); cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    task automatic test_timeout();
        int lat;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_initial: got %0b required 0", timeout); end
        set_delays(0, 0, 1100, 0, 0); cfg_bresp = 2'b00;
        do_txn(1'b1, 32'h10, 32'h5A5A_A5A5, 4'hF, 3'b000, lat);
        ref_wr(32'h10, 32'h5A5A_A5A5, 4'hF); ref_resp(2'b00);
        checks++; if (g_tmo_first < 1025 || g_tmo_first > 1026) begin
            errors++; $display("FAIL tmo_onset: got cycle %0d required 1025..1026", g_tmo_first); end
        checks++; if (lat !== 1103) begin errors++; $display("FAIL tmo_delivered: got latency %0d required 1103", lat); end
        checks++; if (g_resp !== 2'b00) begin errors++; $display("FAIL tmo_resp: got %0d required 0", g_resp); end
        set_delays(0, 0, 0, 0, 0);
        do_txn(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, lat);
        ref_resp(2'b00);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b required 1", timeout); end
        checks++; if (g_rdata !== ref_rd(32'h10)) begin errors++; $display("FAIL tmo_readback: got %h required %h", g_rdata, ref_rd(32'h10)); end
    endtask

    task automatic test_rsp_hold();
        int n;
        logic [31:0] exp_d;
        set_delays(0, 0, 0, 0, 0); cfg_rresp = 2'b00;
        exp_d = ref_rd(32'h4);
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4; cmd_prot = 3'b000; rsp_ready = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 50);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_rsp_wait: got %0b required 1", rsp_valid); end
        ref_resp(2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checks++;
            if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready} !== {1'b1, 1'b0, 2'b00, exp_d, 1'b0}) begin
                errors++; $display("FAIL hold_stable: v=%0b wr=%0b resp=%0d data=%h cr=%0b required 1/0/0/%h/0",
                    rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, exp_d); end
        end
        @(posedge ACLK); #1 rsp_ready = 1'b1;
        @(negedge ACLK);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_no_same_cycle_accept: got %0b required 0", cmd_ready); end
        @(negedge ACLK);
        checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++; $display("FAIL hold_release: v=%0b cr=%0b required 0/1", rsp_valid, cmd_ready); end
        @(posedge ACLK); #1 cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!rsp_valid && n < 50);
        ref_resp(2'b00);
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, exp_d}) begin
            errors++; $display("FAIL hold_second: v=%0b data=%h required 1/%h", rsp_valid, rsp_rdata, exp_d); end
        @(posedge ACLK); #1 rsp_ready = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_reset_midop();
        int n;
        set_delays(5, 0, 0, 0, 0);
        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!cmd_ready && n < 50);
        @(posedge ACLK); #1 cmd_valid = 1'b0;
        @(negedge ACLK);
        checks++; if (M_AXI_AWVALID !== 1'b1) begin errors++; $display("FAIL midop_pending: awvalid=%0b required 1", M_AXI_AWVALID); end
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready} !== 7'b0000001) begin
            errors++; $display("FAIL midop_reset: aw/w/b/ar/r/rsp/cr=%b required 0000001",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready}); end
        checks++; if ({timeout, error_count} !== 9'h0) begin
            errors++; $display("FAIL midop_flags: tmo=%0b err=%0d required 0/0", timeout, error_count); end
        exp_err = 0;
        set_delays(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_min_write();
        test_aw_delay();
        test_read_delay();
        test_errors();
        test_random(40);
        test_timeout();
        test_rsp_hold();
        test_reset_midop();
        test_random(20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Synthesizable AXI4-Lite initiator. It turns single-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions, and returns the read data and response code on a valid/ready response port. It is the master-side counterpart of the AXI4-Lite register slaves. Fabric logic and self-test sequencers use it to program and read back register blocks without a BFM. One transaction is in flight at a time.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width.
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 or 64).
TIMEOUT_CYCLES, 1024, stall-cycle limit before the timeout flag sets; 0 disables the check.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous reset, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when high with cmd_valid.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes.
cmd_prot  in  3  driven onto AWPROT/ARPROT.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed.
rsp_write  out  1  echo of cmd_write.
rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
rsp_resp  out  2  BRESP or RRESP.
error_count  out  8  saturating count of non-OKAY responses.
timeout  out  1  sticky stall flag.
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels, widths per parameters.

Behaviour:
- Reset values: all outputs are registered and reset to 0, except cmd_ready, which resets to 1.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch addr, wdata, wstrb, prot and write; drop cmd_ready.
  - Go to WR_ADDR_DATA if write, else RD_ADDR.
- WR_ADDR_DATA: AWVALID and WVALID rise together on the cycle after acceptance.
  - Each VALID falls on the cycle after its own handshake.
  - AW and W may complete in the same cycle or in either order.
  - Go to WR_RESP once both handshakes are done.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, drop BREADY, go to RSP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP, go to RSP.
- RSP: rsp_valid=1; rsp fields are held stable until rsp_ready. Then rsp_valid=0, cmd_ready=1, return to IDLE.
- A new command cannot be accepted in the same cycle as the rsp_ready handshake.
- Minimum latency with slave always ready and same-cycle responses:
  - write: accept at cycle 0, AW/W handshake at 1, B handshake at 2, rsp_valid at 3;
  - read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- VALID signals never drop before their handshake completes (AXI rule).
- Payload signals are stable while VALID is high.
- error_count: +1 on every B/R response with resp≠2'b00; holds at 255.
- Timeout:
  - A stall counter runs in any non-IDLE, non-RSP state and clears on every channel handshake.
  - When it reaches TIMEOUT_CYCLES, timeout=1 and stays set until ARESET.
  - The FSM keeps waiting; it never abandons a transaction.
- Reset mid-operation: every VALID/READY drops and the FSM returns to IDLE on the next edge. The attached slave shares ARESET.

Test Plan:
- Write 0x0101FFFF to addr 0x0, wstrb 0xF, slave always ready -> AWVALID/WVALID high at cycle 1 only; rsp_valid at cycle 3; rsp_resp=00; rsp_write=1; rsp_rdata=0.
- Write 0xABCD0001 to 0x4 with AWREADY delayed 3 cycles and WREADY immediate -> WVALID falls after cycle 1; AWVALID held with stable AWADDR=0x4 until handshake; BREADY only after both handshakes.
- Read 0x4 after the previous write, RVALID delayed 2 cycles -> rsp_rdata=0xABCD0001, rsp_resp=00, rsp_write=0, rsp_valid at cycle 5.
- Slave returns SLVERR (10) on 3 writes, then 300 DECERR reads -> rsp_resp matches each response; error_count reaches 3, then saturates at 255.
- BVALID withheld 1100 cycles with TIMEOUT_CYCLES=1024 -> timeout=1 from the 1024th stall cycle; response is still delivered when BVALID arrives; timeout stays set until ARESET.
- rsp_ready low for 5 cycles while cmd_valid is held -> rsp fields stable, cmd_ready=0 throughout; ARESET pulsed mid-write -> all valids 0 and cmd_ready=1 on the next cycle.
